// File: rtl/output_line_buffer.sv
// output_line_buffer
//   FIFO of DEPTH full-width words (IN_W bits) written from the frame-decode
//   side and read out as RATIO = IN_W/OUT_W narrower slices, LSB slice first,
//   over a valid/ready stream toward the output formatter.
//
// Optional feature: define OLB_FLUSH_EN to add the i_flush port, a
//   synchronous discard of all buffered words (memory contents are kept).
//
// Ports
//   i_clk      sole clock, rising edge
//   i_reset_n  asynchronous active-low reset (clears pointers, count, memory)
//   i_flush    synchronous discard (OLB_FLUSH_EN only)
//   i_wdata    write word
//   i_wvalid   write request; accepted when o_wready is high
//   o_wready   buffer can accept a word (not full)
//   o_rdata    current head slice, zero when nothing is stored
//   o_rvalid   o_rdata holds valid data
//   i_rready   consumer accepts the current slice
//   o_count    words stored, including a partially read head word
//   o_full     o_count == DEPTH
//   o_empty    o_count == 0
module output_line_buffer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int DEPTH = 5
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
`ifdef OLB_FLUSH_EN
  input  logic                       i_flush,
`endif
  input  logic [IN_W-1:0]            i_wdata,
  input  logic                       i_wvalid,
  output logic                       o_wready,
  output logic [OUT_W-1:0]           o_rdata,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int SL_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [IN_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SL_W-1:0]  sl_q, sl_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, flush;
  logic wr_acc, rd_xfer, last_sl, word_done;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_acc    = i_wvalid && !full;
  assign rd_xfer   = !empty && i_rready;
  assign last_sl   = (sl_q == SL_W'(RATIO - 1));
  assign word_done = rd_xfer && last_sl;

`ifdef OLB_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Outputs depend only on registered state, never on i_wvalid/i_rready.
  assign o_wready = !full;
  assign o_rvalid = !empty;
  assign o_full   = full;
  assign o_empty  = empty;
  assign o_count  = count_q;
  assign o_rdata  = empty ? '0 : mem_q[rd_ptr_q][int'(sl_q)*OUT_W +: OUT_W];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sl_d     = sl_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins over any concurrent write or slice transfer.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      sl_d     = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_xfer) begin
        if (last_sl) begin
          sl_d     = '0;
          rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end else begin
          sl_d = sl_q + 1'b1;
        end
      end
      case ({wr_acc, word_done})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sl_q     <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sl_q     <= sl_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_output_line_buffer.sv
module tb_output_line_buffer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int DEPTH = 5;
  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               i_clk;
  logic               i_reset_n;
`ifdef OLB_FLUSH_EN
  logic               i_flush;
`endif
  logic [IN_W-1:0]    i_wdata;
  logic               i_wvalid;
  logic               o_wready;
  logic [OUT_W-1:0]   o_rdata;
  logic               o_rvalid;
  logic               i_rready;
  logic [CNT_W-1:0]   o_count;
  logic               o_full;
  logic               o_empty;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard model: expected slices in delivery order plus word count.
  logic [OUT_W-1:0] sb[$];
  int               m_count = 0;
  int               m_sl    = 0;

  output_line_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
`ifdef OLB_FLUSH_EN
    .i_flush   (i_flush),
`endif
    .i_wdata   (i_wdata),
    .i_wvalid  (i_wvalid),
    .o_wready  (o_wready),
    .o_rdata   (o_rdata),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready),
    .o_count   (o_count),
    .o_full    (o_full),
    .o_empty   (o_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: at the falling edge, compare outputs with the model, then
  // advance the model by what the coming rising edge will do.
  always @(negedge i_clk or negedge i_reset_n) begin
    logic [CNT_W+3:0] exp_flags;
    logic [OUT_W-1:0] exp_data;
    logic             fl;
    if (!i_reset_n) begin
      sb.delete();
      m_count = 0;
      m_sl    = 0;
    end else begin
      exp_flags = {CNT_W'(m_count), (m_count == 0), (m_count == DEPTH),
                   (m_count != DEPTH), (m_count != 0)};
      n_checks++;
      if ({o_count, o_empty, o_full, o_wready, o_rvalid} !== exp_flags) begin
        n_fail++;
        $display("FAIL sb_flags @%0t: got cnt=%0d e=%b f=%b wr=%b rv=%b, expected %b",
                 $time, o_count, o_empty, o_full, o_wready, o_rvalid, exp_flags);
      end
      exp_data = (m_count != 0 && sb.size() != 0) ? sb[0] : '0;
      n_checks++;
      if (o_rdata !== exp_data) begin
        n_fail++;
        $display("FAIL sb_rdata @%0t: got %h expected %h", $time, o_rdata, exp_data);
      end
      fl = 1'b0;
`ifdef OLB_FLUSH_EN
      fl = i_flush;
`endif
      if (fl) begin
        sb.delete();
        m_count = 0;
        m_sl    = 0;
      end else begin
        int delta;
        delta = 0;
        if (i_wvalid && m_count < DEPTH) begin
          for (int k = 0; k < RATIO; k++) sb.push_back(i_wdata[k*OUT_W +: OUT_W]);
          delta++;
        end
        if (m_count > 0 && i_rready) begin
          void'(sb.pop_front());
          if (m_sl == RATIO - 1) begin
            m_sl = 0;
            delta--;
          end else begin
            m_sl++;
          end
        end
        m_count += delta;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n;
    n = 0;
    while (o_empty !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    n_checks++;
    if (o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: drain timeout, o_empty=%b expected 1", name, o_empty);
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_wvalid  = 1'b0;
    i_rready  = 1'b1;
    i_wdata   = '0;
`ifdef OLB_FLUSH_EN
    i_flush   = 1'b0;
`endif
    #1;
    n_checks++;
    if ({o_rdata, o_rvalid, o_empty, o_full, o_count, o_wready} !==
        {32'h0, 1'b0, 1'b1, 1'b0, CNT_W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL reset_vals: got rdata=%h rv=%b e=%b f=%b cnt=%0d wr=%b",
               o_rdata, o_rvalid, o_empty, o_full, o_count, o_wready);
    end
    step();
    step();
    i_reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    i_rready = 1'b1;
    i_wdata  = 64'h1111_2222_3333_4444;
    i_wvalid = 1'b1;
    step();
    i_wvalid = 1'b0;
    n_checks++;
    if (o_rdata !== 32'h3333_4444 || o_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL single_s0: got rdata=%h cnt=%0d expected 33334444 cnt=1", o_rdata, o_count);
    end
    step();
    n_checks++;
    if (o_rdata !== 32'h1111_2222 || o_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL single_s1: got rdata=%h cnt=%0d expected 11112222 cnt=1", o_rdata, o_count);
    end
    step();
    n_checks++;
    if (o_empty !== 1'b1 || o_count !== CNT_W'(0)) begin
      n_fail++;
      $display("FAIL single_done: got e=%b cnt=%0d expected e=1 cnt=0", o_empty, o_count);
    end
  endtask

  task automatic test_fill_drain();
    i_rready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      i_wdata  = {8'hA0 + 8'(w), 24'h0, 8'hB0 + 8'(w), 24'h5};
      i_wvalid = 1'b1;
      step();
      if (w == 4) begin
        n_checks++;
        if (o_full !== 1'b1 || o_wready !== 1'b0 || o_count !== CNT_W'(5)) begin
          n_fail++;
          $display("FAIL fill_full: got f=%b wr=%b cnt=%0d expected f=1 wr=0 cnt=5",
                   o_full, o_wready, o_count);
        end
      end
    end
    i_wvalid = 1'b0;
    n_checks++;
    if (o_count !== CNT_W'(5) || o_rdata !== 32'hB000_0005) begin
      n_fail++;
      $display("FAIL sixth_ignored: got cnt=%0d rdata=%h expected cnt=5 rdata=b0000005",
               o_count, o_rdata);
    end
    i_rready = 1'b1;
    wait_empty("fill_drain", 20);
    // Refill with pointers already wrapped.
    i_rready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      i_wdata  = {32'hC0DE_0000 + 32'(w), 32'hFACE_0000 + 32'(w)};
      i_wvalid = 1'b1;
      step();
    end
    i_wvalid = 1'b0;
    n_checks++;
    if (o_count !== CNT_W'(3)) begin
      n_fail++;
      $display("FAIL refill_cnt: got %0d expected 3", o_count);
    end
    i_rready = 1'b1;
    wait_empty("refill_drain", 20);
  endtask

  task automatic test_simul_wr_rel();
    i_rready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      i_wdata  = {32'h2222_0000 + 32'(w), 32'h1111_0000 + 32'(w)};
      i_wvalid = 1'b1;
      step();
    end
    i_wvalid = 1'b0;
    i_rready = 1'b1;
    step();
    i_wdata  = 64'h4444_4444_3333_3333;
    i_wvalid = 1'b1;
    step();
    i_wvalid = 1'b0;
    i_rready = 1'b0;
    n_checks++;
    if (o_count !== CNT_W'(2) || o_rdata !== 32'h1111_0001) begin
      n_fail++;
      $display("FAIL simul_wr_rel: got cnt=%0d rdata=%h expected cnt=2 rdata=11110001",
               o_count, o_rdata);
    end
    i_rready = 1'b1;
    wait_empty("simul_drain", 20);
  endtask

  task automatic test_hold_and_reset();
    logic [IN_W-1:0] w;
    w = 64'hDEAD_BEEF_0BAD_F00D;
    i_rready = 1'b0;
    i_wdata  = w;
    i_wvalid = 1'b1;
    step();
    i_wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (o_rdata !== w[31:0] || o_rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stable c%0d: got rdata=%h rv=%b expected %h rv=1",
                 c, o_rdata, o_rvalid, w[31:0]);
      end
      step();
    end
    i_rready = 1'b1;
    step();
    i_rready = 1'b0;
    #3;
    i_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_rdata, o_rvalid, o_empty, o_full, o_count, o_wready} !==
        {32'h0, 1'b0, 1'b1, 1'b0, CNT_W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL midword_reset: got rdata=%h rv=%b e=%b f=%b cnt=%0d wr=%b",
               o_rdata, o_rvalid, o_empty, o_full, o_count, o_wready);
    end
    step();
    i_reset_n = 1'b1;
    w = 64'h7777_6666_5555_4444;
    i_wdata  = w;
    i_wvalid = 1'b1;
    i_rready = 1'b1;
    step();
    i_wvalid = 1'b0;
    n_checks++;
    if (o_rdata !== w[31:0]) begin
      n_fail++;
      $display("FAIL post_reset_s0: got %h expected %h", o_rdata, w[31:0]);
    end
    wait_empty("post_reset_drain", 10);
  endtask

`ifdef OLB_FLUSH_EN
  task automatic test_flush();
    i_rready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      i_wdata  = {32'h9000_0000 + 32'(w), 32'h8000_0000 + 32'(w)};
      i_wvalid = 1'b1;
      step();
    end
    i_wdata  = 64'hEEEE_EEEE_EEEE_EEEE;
    i_flush  = 1'b1;
    step();
    i_flush  = 1'b0;
    i_wvalid = 1'b0;
    n_checks++;
    if (o_count !== CNT_W'(0) || o_empty !== 1'b1 || o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL flush: got cnt=%0d e=%b rdata=%h expected cnt=0 e=1 rdata=0",
               o_count, o_empty, o_rdata);
    end
    i_wdata  = 64'h1234_5678_9ABC_DEF0;
    i_wvalid = 1'b1;
    step();
    i_wvalid = 1'b0;
    n_checks++;
    if (o_rdata !== 32'h9ABC_DEF0 || o_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL post_flush: got rdata=%h cnt=%0d expected 9abcdef0 cnt=1", o_rdata, o_count);
    end
    i_rready = 1'b1;
    wait_empty("flush_drain", 10);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_wdata  = {$urandom, $urandom};
      i_wvalid = ($urandom_range(0, 3) != 0);
      i_rready = ($urandom_range(0, 2) != 0);
      step();
    end
    i_wvalid = 1'b0;
    i_rready = 1'b1;
    wait_empty("random_drain", 40);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_simul_wr_rel();
    test_hold_and_reset();
`ifdef OLB_FLUSH_EN
    test_flush();
`endif
    test_random();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
